move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: btn_dir  in  4  raw asynchronous direction buttons, active-high; 0001 top, 0010 bottom, 0100 left, 1000 right.
REQ-004 SHALL have port: game_state  in  2  core status; 00 not_playing, 01 playing, 10 win, 11 lose.
REQ-005 SHALL have port: move_ready  in  1  core accepts a move this cycle.
REQ-006 SHALL have port: move_done  in  1  one-cycle pulse when the core finishes move, merge and new-tile placement.
REQ-007 SHALL have port: move_dir  out  4  one-hot direction offered to the core; 0000 when move_valid is low.
REQ-008 SHALL have port: move_valid  out  1  move offer.
REQ-009 SHALL have port: busy  out  1  high in ISSUE or WAIT.
REQ-010 SHALL have port: drop_count  out  8  saturating count of discarded presses.
REQ-011 SHALL have port: timeout_err  out  1  sticky flag when the core fails to finish a move.

Function
REQ-012 SHALL pass btn_dir through a 2-flop synchronizer; press detected when the synchronized value is exactly one-hot and the previous synchronized value was 0000.
REQ-013 SHALL ignore multi-hot values and held buttons: no press, drop_count unchanged.
REQ-014 SHALL, on a press while game_state=01, write the direction into the move queue at the edge following detection; queue empty and FSM in IDLE gives move_valid high 3 cycles after btn_dir first becomes stable.
REQ-015 SHALL, on a press while game_state≠01, discard it and increment drop_count.
REQ-016 SHALL, on a press with the queue full and no pop in the same cycle, discard it and increment drop_count; a simultaneous pop frees the slot and the press is accepted.
REQ-017 SHALL saturate drop_count at 255.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-019 SHALL move IDLE->ISSUE when the queue is non-empty and game_state=01.
REQ-020 SHALL, in ISSUE, hold move_valid=1 and move_dir=queue head stable until move_valid&&move_ready; at that edge pop the queue and enter WAIT.
REQ-021 SHALL, in WAIT, keep move_valid=0 and go to IDLE on move_done.
REQ-022 SHALL run an 8-bit cycle counter in WAIT; reaching 255 without move_done sets timeout_err and forces IDLE.
REQ-023 SHALL treat move_done outside WAIT as ignored.
REQ-024 SHALL, when game_state becomes 10 or 11, flush the queue and go to IDLE from any state by the next edge; a pending ISSUE offer is withdrawn.
REQ-025 SHALL, when game_state is 00 in ISSUE, return to IDLE without popping.

Reset
REQ-026 SHALL, on rst, clear synchronizer and edge flops, empty the queue, and enter IDLE.
REQ-027 SHALL, on rst, drive move_valid=0, move_dir=0000, busy=0, drop_count=0, timeout_err=0.
REQ-028 SHALL apply rst mid-handshake or mid-WAIT with the same result; no move is emitted in the cycle after rst.

Configuration
REQ-029 SHALL, with MOVE_SCHEDULER_QUEUE_EN defined, use a 4-entry FIFO queue with wrap-around 2-bit pointers and a 3-bit count.
REQ-030 SHALL, without MOVE_SCHEDULER_QUEUE_EN, use a single-entry holding register: full while occupied, presses while full dropped per REQ-016.

Structure
REQ-031 SHALL take direction one-hot constants, game_state encodings, and the sched_state_t enum (IDLE, ISSUE, WAIT) from shared package game2048_pkg.
REQ-032 SHALL place queue storage in sub-module move_fifo (push, pop, head, full, empty) parameterized by depth; depth 1 in the non-queue build.

Verification
REQ-033 SHALL cover: game_state=01, btn_dir=0100 held 10 cycles, move_ready=1 -> exactly one move_valid cycle with move_dir=0100, 3 cycles after stimulus; drop_count=0.
REQ-034 SHALL cover: queue build, 6 distinct presses during WAIT -> 4 moves issued in press order after successive move_done; drop_count=2.
REQ-035 SHALL cover: btn_dir=0110 -> no move, drop_count=0; game_state=00 then press 0001 -> no move, drop_count=1.
REQ-036 SHALL cover: handshake accepted, move_done withheld -> timeout_err=1 on the 255th WAIT cycle, FSM IDLE, the next press still issues.
REQ-037 SHALL cover: 2 entries queued, game_state->10 during ISSUE -> move_valid low next cycle, queue empty, no further moves.

Source files
------------

// File: rtl/game2048_pkg.sv
// Shared 2048 constants: direction one-hots, core game_state encodings, scheduler state enum.
package game2048_pkg;
  localparam int unsigned DIR_W = 4;
  localparam int unsigned GS_W  = 2;
  localparam int unsigned CNT_W = 8;

  localparam logic [DIR_W-1:0] DIR_TOP    = 4'b0001;
  localparam logic [DIR_W-1:0] DIR_BOTTOM = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_LEFT   = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_RIGHT  = 4'b1000;

  localparam logic [GS_W-1:0] GS_NOT_PLAYING = 2'b00;
  localparam logic [GS_W-1:0] GS_PLAYING     = 2'b01;
  localparam logic [GS_W-1:0] GS_WIN         = 2'b10;
  localparam logic [GS_W-1:0] GS_LOSE        = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  function automatic logic is_dir(input logic [DIR_W-1:0] v);
    return (v == DIR_TOP) || (v == DIR_BOTTOM) || (v == DIR_LEFT) || (v == DIR_RIGHT);
  endfunction
endpackage

// File: rtl/move_fifo.sv
// Pending-move storage: ring buffer for DEPTH>1, plain holding register for DEPTH==1.
module move_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  if (DEPTH == 1) begin : g_reg
    logic [W-1:0] data;
    logic         occupied;

    // A push with a same-cycle pop simply replaces the held entry.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        occupied <= 1'b0;
      end else if (push) begin
        occupied <= 1'b1;
      end else if (pop) begin
        occupied <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (push) data <= din;
    end

    assign head  = data;
    assign full  = occupied;
    assign empty = !occupied;
  end else begin : g_ring
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= inc(wptr);
        if (pop)  rptr <= inc(rptr);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
    end

    assign head  = mem[rptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
  end
endmodule

// File: rtl/move_scheduler.sv
// Debounced button-to-move scheduler for the 2048 core with timeout and drop accounting.
// MOVE_SCHEDULER_QUEUE_EN selects a 4-deep move queue; otherwise a single holding register.
module move_scheduler
  import game2048_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIR_W-1:0] btn_dir,
  input  logic [GS_W-1:0]  game_state,
  input  logic             move_ready,
  input  logic             move_done,
  output logic [DIR_W-1:0] move_dir,
  output logic             move_valid,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count,
  output logic             timeout_err
);
`ifdef MOVE_SCHEDULER_QUEUE_EN
  localparam int unsigned QUEUE_DEPTH = 4;
`else
  localparam int unsigned QUEUE_DEPTH = 1;
`endif

  sched_state_t     state;
  logic [DIR_W-1:0] sync1, sync2, prev;
  logic [CNT_W-1:0] wait_cnt;
  logic [DIR_W-1:0] head;
  logic             full, empty;
  logic             playing_c, flush_c, press_c, pop_c, accept_c, drop_c;

  // Two-flop synchronizer plus one history flop for press edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn_dir;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign playing_c = (game_state == GS_PLAYING);
  assign flush_c   = (game_state == GS_WIN) || (game_state == GS_LOSE);
  assign press_c   = is_dir(sync2) && (prev == '0);
  assign pop_c     = (state == ISSUE) && move_valid && move_ready && playing_c;
  assign accept_c  = press_c && playing_c && (!full || pop_c);
  assign drop_c    = press_c && !accept_c;

  move_fifo #(.DEPTH(QUEUE_DEPTH), .W(DIR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_c),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (sync2),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Scheduler FSM; an empty queue with an incoming press offers that press directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      move_valid  <= 1'b0;
      move_dir    <= '0;
      busy        <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (drop_c && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);

      if (flush_c) begin
        state      <= IDLE;
        move_valid <= 1'b0;
        move_dir   <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (playing_c && (!empty || accept_c)) begin
              state      <= ISSUE;
              move_valid <= 1'b1;
              move_dir   <= empty ? sync2 : head;
              busy       <= 1'b1;
            end
          end
          ISSUE: begin
            if (game_state == GS_NOT_PLAYING) begin
              state      <= IDLE;
              move_valid <= 1'b0;
              move_dir   <= '0;
              busy       <= 1'b0;
            end else if (move_ready) begin
              state      <= WAIT;
              move_valid <= 1'b0;
              move_dir   <= '0;
              wait_cnt   <= '0;
            end
          end
          WAIT: begin
            if (move_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (wait_cnt == CNT_W'(254)) begin
              state       <= IDLE;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          default: begin
            state      <= IDLE;
            move_valid <= 1'b0;
            move_dir   <= '0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler; expected moves are queued at press time, a negedge monitor checks offers.
module tb_move_scheduler;
  import game2048_pkg::*;

`ifdef MOVE_SCHEDULER_QUEUE_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_dir;
  logic [1:0] game_state;
  logic       move_ready;
  logic       move_done;
  logic [3:0] move_dir;
  logic       move_valid;
  logic       busy;
  logic [7:0] drop_count;
  logic       timeout_err;

  int         checks = 0;
  int         errors = 0;
  int         exp_drop = 0;
  logic [3:0] exp_q[$];
  logic [3:0] dirs[4];

  move_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .btn_dir     (btn_dir),
    .game_state  (game_state),
    .move_ready  (move_ready),
    .move_done   (move_done),
    .move_dir    (move_dir),
    .move_valid  (move_valid),
    .busy        (busy),
    .drop_count  (drop_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every offered move must match the oldest expected move; idle bus must be zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (move_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_move: move_dir=%b offered with nothing expected", move_dir);
        end else begin
          check("move_dir", 32'(move_dir), 32'(exp_q[0]));
          if (move_ready && game_state == 2'b01) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_dir_zero", 32'(move_dir), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference rule: a press is kept only while playing and while the queue has room.
  task automatic model_press(input logic [3:0] d);
    if (game_state != 2'b01 || exp_q.size() >= DEPTH) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      exp_q.push_back(d);
    end
  endtask

  task automatic press(input logic [3:0] d);
    btn_dir = d;
    tick(4);
    btn_dir = 4'b0000;
    tick(3);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40 && !move_valid; i++) tick(1);
    check(name, 32'(move_valid), 32'd1);
  endtask

  task automatic handshake();
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
  endtask

  task automatic pulse_done();
    move_done = 1'b1;
    tick(1);
    move_done = 1'b0;
  endtask

  task automatic serve(input int dly);
    wait_valid("serve_valid");
    tick($urandom_range(0, 2));
    handshake();
    tick(dly);
    pulse_done();
  endtask

  initial begin
    int first_k, vcnt, wcnt, n;
    logic [3:0] d;
    dirs[0] = DIR_TOP; dirs[1] = DIR_BOTTOM; dirs[2] = DIR_LEFT; dirs[3] = DIR_RIGHT;
    rst = 1'b1; btn_dir = '0; game_state = 2'b01; move_ready = 1'b0; move_done = 1'b0;
    tick(3);
    check("rst_valid", 32'(move_valid), 32'd0);
    check("rst_dir", 32'(move_dir), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // Held LEFT with ready high: one offer, three edges after the button is applied.
    move_ready = 1'b1;
    btn_dir = DIR_LEFT;
    model_press(DIR_LEFT);
    first_k = 0; vcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (move_valid) begin
        vcnt++;
        if (first_k == 0) first_k = k;
      end
      if (k == 10) btn_dir = '0;
    end
    move_ready = 1'b0;
    check("latency_edges", 32'(first_k), 32'd3);
    check("single_offer", 32'(vcnt), 32'd1);
    pulse_done();
    check("drop_after_held", 32'(drop_count), 32'(exp_drop));

    // Random single presses with random ready and done delays.
    for (int it = 0; it < 8; it++) begin
      d = dirs[$urandom_range(0, 3)];
      model_press(d);
      press(d);
      serve($urandom_range(1, 10));
      check("busy_after_done", 32'(busy), 32'd0);
    end

    // Burst of six presses while the core is busy.
    d = dirs[$urandom_range(0, 3)];
    model_press(d);
    press(d);
    wait_valid("burst_first");
    handshake();
    for (int i = 0; i < 6; i++) begin
      d = dirs[$urandom_range(0, 3)];
      model_press(d);
      press(d);
    end
    check("burst_drop", 32'(drop_count), 32'(exp_drop));
    n = exp_q.size();
    check("burst_kept", 32'(n), 32'(DEPTH));
    pulse_done();
    for (int i = 0; i < n; i++) serve($urandom_range(1, 4));
    check("burst_drained", 32'(exp_q.size()), 32'd0);

    // Multi-hot is ignored; presses while not playing are dropped.
    btn_dir = 4'b0110;
    tick(6);
    btn_dir = '0;
    tick(4);
    check("multihot_drop", 32'(drop_count), 32'(exp_drop));
    check("multihot_busy", 32'(busy), 32'd0);
    game_state = 2'b00;
    model_press(DIR_TOP);
    press(DIR_TOP);
    check("notplay_drop", 32'(drop_count), 32'(exp_drop));
    game_state = 2'b01;
    tick(5);
    check("notplay_nomove", 32'(move_valid), 32'd0);

    // Core never finishes: timeout after 255 WAIT cycles, then service resumes.
    d = dirs[$urandom_range(0, 3)];
    model_press(d);
    press(d);
    wait_valid("to_valid");
    handshake();
    wcnt = 0;
    for (int i = 0; i < 400 && !timeout_err; i++) begin
      if (busy && !move_valid) wcnt++;
      tick(1);
    end
    check("timeout_wait_cycles", 32'(wcnt), 32'd255);
    check("timeout_flag", 32'(timeout_err), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    d = dirs[$urandom_range(0, 3)];
    model_press(d);
    press(d);
    serve(3);
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // Win during ISSUE with entries queued: offer withdrawn and queue flushed.
    d = dirs[$urandom_range(0, 3)];
    model_press(d);
    press(d);
    wait_valid("flush_first");
    handshake();
    for (int i = 0; i < ((DEPTH < 2) ? DEPTH : 2); i++) begin
      d = dirs[$urandom_range(0, 3)];
      model_press(d);
      press(d);
    end
    pulse_done();
    wait_valid("flush_issue");
    game_state = 2'b10;
    tick(1);
    exp_q.delete();
    check("flush_valid", 32'(move_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    tick(2);
    game_state = 2'b01;
    tick(20);
    check("flush_nomore", 32'(move_valid), 32'd0);

    // Reset while an offer is pending.
    d = dirs[$urandom_range(0, 3)];
    model_press(d);
    press(d);
    wait_valid("rst_mid_valid");
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    exp_drop = 0;
    rst = 1'b0;
    check("rst_mid_valid_low", 32'(move_valid), 32'd0);
    check("rst_mid_drop", 32'(drop_count), 32'd0);
    check("rst_mid_timeout", 32'(timeout_err), 32'd0);
    tick(1);
    check("rst_mid_next", 32'(move_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);

    // Reset while waiting on the core.
    d = dirs[$urandom_range(0, 3)];
    model_press(d);
    press(d);
    wait_valid("rst_wait_valid");
    handshake();
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_wait_busy", 32'(busy), 32'd0);
    tick(1);
    check("rst_wait_next", 32'(move_valid), 32'd0);

    // Saturating drop counter.
    game_state = 2'b00;
    for (int i = 0; i < 260; i++) begin
      model_press(dirs[i % 4]);
      press(dirs[i % 4]);
    end
    check("drop_saturate", 32'(drop_count), 32'(exp_drop));
    game_state = 2'b01;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
